// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } t_arb_state;

  // Width that holds 0..TIMEOUT-1 with one bit of headroom.
  function automatic int c_wd_w(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

  // First requester searching upward from last+1, wrapping at n (n <= 8).
  function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int         n);
    logic [7:0] grant;
    logic       found;
    logic [2:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= n) begin
        idx = 3'((int'(last) + i) % n);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational round-robin picker: one-hot winner after the last granted index.
module rr_pick_onehot
  import wb_rr_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic          o_valid
);

  logic [7:0] w_req8;
  logic [2:0] w_last3;
  logic [7:0] w_grant8;

  always_comb begin
    w_req8           = '0;
    w_req8[N-1:0]    = i_req;
    w_last3          = '0;
    w_last3[LW-1:0]  = i_last;
    w_grant8         = rr_pick(w_req8, w_last3, N);
    o_grant          = w_grant8[N-1:0];
    o_valid          = |w_grant8;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between N_MASTERS masters,
// one transaction in flight, with a watchdog that turns a hung slave into an error.
//
// state     | meaning
// ARB_IDLE  | no grant; pick next requester after last
// ARB_ISSUE | strobe presented to slave until it is accepted
// ARB_WAIT  | strobe accepted, waiting for ack/err/rty
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_MASTERS-1:0]          m_cyc_i,
  input  logic [N_MASTERS-1:0]          m_stb_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_sel_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dat_i,
  output logic [N_MASTERS-1:0]          m_ack_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic [N_MASTERS-1:0]          m_rty_o,
  output logic [N_MASTERS-1:0]          m_stall_o,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_adr_o,
  output logic [DATA_W/8-1:0]           s_sel_o,
  output logic [DATA_W-1:0]             s_dat_o,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  input  logic                          s_stall_i,
  input  logic [DATA_W-1:0]             s_dat_i,
  output logic [N_MASTERS-1:0]          grant_o
);

  localparam int LW    = $clog2(N_MASTERS);
  localparam int WD_W  = c_wd_w(TIMEOUT);
  localparam int SEL_W = DATA_W / 8;

  t_arb_state             r_state;
  logic [N_MASTERS-1:0]   r_grant;
  logic [LW-1:0]          r_last;
  logic [WD_W-1:0]        r_wd;

  logic [N_MASTERS-1:0]   w_req;
  logic [N_MASTERS-1:0]   w_pick;
  logic                   w_pick_valid;
  logic [LW-1:0]          w_pick_idx;
  logic                   w_busy;
  logic                   w_gcyc;
  logic                   w_resp;
  logic                   w_abort;
  logic                   w_wd_fire;

  assign w_req = m_cyc_i & m_stb_i;

  rr_pick_onehot #(
    .N  (N_MASTERS),
    .LW (LW)
  ) u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (w_pick[k]) w_pick_idx = LW'(k);
    end
  end

  // r_grant is zero outside ISSUE/WAIT, so this mux also zeroes the slave bus in IDLE.
  always_comb begin
    w_gcyc  = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_gcyc  = m_cyc_i[k];
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[k*ADDR_W +: ADDR_W];
        s_sel_o = m_sel_i[k*SEL_W +: SEL_W];
        s_dat_o = m_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_busy    = (r_state != ARB_IDLE);
  assign w_resp    = w_busy & (s_ack_i | s_err_i | s_rty_i);
  assign w_abort   = w_busy & ~w_resp & ~w_gcyc;
  assign w_wd_fire = w_busy & ~w_resp & w_gcyc & (r_wd == WD_W'(TIMEOUT - 1));

  assign s_cyc_o = w_busy & ~w_abort & ~w_wd_fire;
  assign s_stb_o = s_cyc_o & (r_state == ARB_ISSUE);

  assign m_ack_o = r_grant & {N_MASTERS{s_ack_i}};
  assign m_err_o = r_grant & {N_MASTERS{s_err_i | w_wd_fire}};
  assign m_rty_o = r_grant & {N_MASTERS{s_rty_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;

  // Only the granted master in ISSUE can see stall low, and only from the slave.
  always_comb begin
    m_stall_o = w_req & ~r_grant;
    if (r_state == ARB_ISSUE) m_stall_o = m_stall_o | (r_grant & {N_MASTERS{s_stall_i}});
    if (r_state == ARB_WAIT)  m_stall_o = m_stall_o | r_grant;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= LW'(N_MASTERS - 1);
      r_wd    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_state <= ARB_ISSUE;
            r_grant <= w_pick;
            r_last  <= w_pick_idx;
            r_wd    <= '0;
          end
        end
        ARB_ISSUE, ARB_WAIT: begin
          if (w_resp | w_abort | w_wd_fire) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
          end else begin
            r_wd <= r_wd + WD_W'(1);
            if ((r_state == ARB_ISSUE) && !s_stall_i) r_state <= ARB_WAIT;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed and randomized checks of wb_rr_arbiter against a cycle-level reference model.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int SW = DW / 8;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*SW-1:0] m_sel_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, m_stall_o, grant_o;
  logic [DW-1:0]   m_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_o;
  logic            s_ack_i, s_err_i, s_rty_i, s_stall_i;
  logic [DW-1:0]   s_dat_i;

  always #5 clk_i = ~clk_i;

  wb_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o), .m_stall_o(m_stall_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner = -1 when no transaction is open.
  int owner = -1;
  int last  = N - 1;
  int age   = 0;
  bit issued_wait = 1'b0;
  int n_owner, n_last, n_age;
  bit n_wait;

  logic [N-1:0]  e_ack, e_err, e_rty, e_stall, e_grant;
  logic          e_cyc, e_stb, e_we;
  logic [AW-1:0] e_adr;
  logic [SW-1:0] e_sel;
  logic [DW-1:0] e_dat;

  logic [N-1:0]  smp_ack, smp_err, smp_grant, smp_stall;
  logic          smp_cyc, smp_stb, smp_we;
  logic [AW-1:0] smp_adr;
  logic [DW-1:0] smp_sdat, smp_mdat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic [N-1:0] req;
    bit resp, abort, wd, found;
    req = m_cyc_i & m_stb_i;
    e_ack = '0; e_err = '0; e_rty = '0; e_grant = '0; e_stall = req;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_dat = '0;
    n_owner = owner; n_last = last; n_age = age; n_wait = issued_wait;
    if (owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (last + i) % N;
        if (!found && req[k]) begin
          found = 1'b1; n_owner = k; n_last = k; n_age = 0; n_wait = 1'b0;
        end
      end
    end else begin
      resp  = s_ack_i | s_err_i | s_rty_i;
      abort = !resp && !m_cyc_i[owner];
      wd    = !resp && !abort && (age == TO - 1);
      e_cyc = !(abort || wd);
      e_stb = e_cyc && !issued_wait;
      e_grant[owner] = 1'b1;
      e_ack[owner]   = s_ack_i;
      e_err[owner]   = s_err_i | wd;
      e_rty[owner]   = s_rty_i;
      e_stall[owner] = issued_wait ? 1'b1 : s_stall_i;
      e_we  = m_we_i[owner];
      e_adr = m_adr_i[owner*AW +: AW];
      e_sel = m_sel_i[owner*SW +: SW];
      e_dat = m_dat_i[owner*DW +: DW];
      if (resp || abort || wd) n_owner = -1;
      else begin
        n_age = age + 1;
        if (!issued_wait && !s_stall_i) n_wait = 1'b1;
      end
    end
  endtask

  // One clock: compare at the falling edge, commit the model at the rising edge.
  task automatic cycle();
    @(negedge clk_i);
    model_eval();
    chk("ack", m_ack_o, e_ack);
    chk("err", m_err_o, e_err);
    chk("rty", m_rty_o, e_rty);
    chk("stall", m_stall_o, e_stall);
    chk("grant", grant_o, e_grant);
    chk("s_cyc", s_cyc_o, e_cyc);
    chk("s_stb", s_stb_o, e_stb);
    chk("s_we", s_we_o, e_we);
    chk("s_adr", s_adr_o, e_adr);
    chk("s_sel", s_sel_o, e_sel);
    chk("s_dat", s_dat_o, e_dat);
    chk("m_dat", m_dat_o, s_dat_i);
    smp_ack = m_ack_o; smp_err = m_err_o; smp_grant = grant_o; smp_stall = m_stall_o;
    smp_cyc = s_cyc_o; smp_stb = s_stb_o; smp_we = s_we_o; smp_adr = s_adr_o;
    smp_sdat = s_dat_o; smp_mdat = m_dat_o;
    @(posedge clk_i);
    if (!rst_n_i) begin
      owner = -1; last = N - 1; age = 0; issued_wait = 1'b0;
    end else begin
      owner = n_owner; last = n_last; age = n_age; issued_wait = n_wait;
    end
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[k] = cyc;
    m_stb_i[k] = stb;
    m_we_i[k]  = we;
    m_adr_i[k*AW +: AW] = adr;
    m_sel_i[k*SW +: SW] = '1;
    m_dat_i[k*DW +: DW] = dat;
  endtask

  task automatic idle_bus();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_stall_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    cycle();
    rst_n_i = 1'b1;
  endtask

  initial begin
    int at, nacks, cnt0, cnt1;
    logic pend;
    idle_bus();
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;

    // Reset state with both masters requesting: nothing granted, everybody stalled.
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    cycle();
    chk("rst_grant", smp_grant, 2'b00);
    chk("rst_stall", smp_stall, 2'b11);
    chk("rst_scyc", smp_cyc, 1'b0);
    idle_bus();
    do_reset();

    // Single read by master 0, slave acks the cycle after the strobe.
    set_m(0, 1, 1, 0, 3'h4, '0);
    cycle();
    chk("t1_arb_stb", smp_stb, 1'b0);
    cycle();
    chk("t1_stb", smp_stb, 1'b1);
    chk("t1_adr", smp_adr, 3'h4);
    set_m(0, 1, 0, 0, 3'h4, '0);
    s_ack_i = 1; s_dat_i = 32'hCAFE0001;
    cycle();
    chk("t1_ack", smp_ack, 2'b01);
    chk("t1_dat", smp_mdat, 32'hCAFE0001);
    chk("t1_wait_stb", smp_stb, 1'b0);
    idle_bus();
    cycle();

    // Two masters requesting continuously from reset alternate 0,1,0,1.
    do_reset();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    pend = 0; nacks = 0; cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (nacks < 4) begin
        s_ack_i = pend; s_dat_i = $urandom;
        cycle();
        if (smp_ack != 0) begin
          chk("t2_ack_order", smp_ack, (nacks % 2 == 0) ? 2'b01 : 2'b10);
          if (smp_ack[0]) cnt0++;
          if (smp_ack[1]) cnt1++;
          nacks++;
        end
        pend = smp_stb;
      end
    end
    chk("t2_nacks", nacks, 4);
    chk("t2_cnt0", cnt0, 2);
    chk("t2_cnt1", cnt1, 2);
    idle_bus();
    cycle();
    cycle();

    // Hung slave: watchdog error on the 16th ISSUE/WAIT cycle, then normal arbitration.
    do_reset();
    set_m(0, 1, 1, 0, 3'h0, '0);
    s_stall_i = 1;
    cycle();
    at = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (at < 0 && smp_err != 0) begin
        at = i;
        chk("t3_err", smp_err, 2'b01);
        chk("t3_scyc", smp_cyc, 1'b0);
        set_m(0, 0, 0, 0, '0, '0);
        set_m(1, 1, 1, 0, 3'h4, '0);
      end else if (at > 0 && i == at + 2) begin
        chk("t3_next_grant", smp_grant, 2'b10);
        chk("t3_next_stb", smp_stb, 1'b1);
      end
    end
    chk("t3_at", at, TO);
    idle_bus();
    cycle();
    cycle();

    // Master 1 abandons its cycle in WAIT; a late ack must not reach anyone.
    do_reset();
    set_m(1, 1, 1, 0, 3'h0, '0);
    cycle();
    cycle();
    chk("t4_grant", smp_grant, 2'b10);
    set_m(1, 0, 0, 0, 3'h0, '0);
    cycle();
    chk("t4_scyc", smp_cyc, 1'b0);
    s_ack_i = 1;
    cycle();
    chk("t4_late_ack", smp_ack, 2'b00);
    chk("t4_idle_grant", smp_grant, 2'b00);
    s_ack_i = 0;

    // Slave error on a write by master 0.
    set_m(0, 1, 1, 1, 3'h4, 32'h12345678);
    cycle();
    cycle();
    chk("t5_sdat", smp_sdat, 32'h12345678);
    chk("t5_we", smp_we, 1'b1);
    set_m(0, 1, 0, 1, 3'h4, 32'h12345678);
    s_err_i = 1;
    cycle();
    chk("t5_err", smp_err, 2'b01);
    chk("t5_ack", smp_ack, 2'b00);
    idle_bus();
    cycle();
    chk("t5_err_clear", smp_err, 2'b00);

    // Reset pulse during WAIT; afterwards master 0 wins again.
    set_m(1, 1, 1, 0, 3'h0, '0);
    cycle();
    cycle();
    rst_n_i = 1'b0;
    set_m(0, 1, 1, 0, 3'h4, '0);
    cycle();
    rst_n_i = 1'b1;
    cycle();
    chk("t6_scyc", smp_cyc, 1'b0);
    chk("t6_grant_idle", smp_grant, 2'b00);
    cycle();
    chk("t6_grant0", smp_grant, 2'b01);
    idle_bus();
    cycle();
    cycle();

    // Random traffic: busy slave, then a rarely-answering slave to reach the watchdog.
    do_reset();
    for (int i = 0; i < 1800; i++) begin
      int ack_div;
      ack_div = (i < 1200) ? 4 : 40;
      for (int k = 0; k < N; k++) begin
        set_m(k, ($urandom % 8) != 0, ($urandom % 4) != 0, $urandom % 2,
              AW'($urandom), $urandom);
        m_sel_i[k*SW +: SW] = SW'($urandom);
      end
      s_stall_i = ($urandom % 3) == 0;
      s_ack_i   = ($urandom % ack_div) == 0;
      s_err_i   = ($urandom % (ack_div * 4)) == 0;
      s_rty_i   = ($urandom % (ack_div * 4)) == 0;
      s_dat_i   = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
